// File: rtl/mat_res_serializer_if.sv
// Result hand-off bus: packed 2x2 result + aux in, one serialized word per transfer out.
// master = producer/consumer side, slave = serializer.
interface mat_res_serializer_if #(
  parameter int W = 32
);
  logic [4*W-1:0] in_res;
  logic [W-1:0]   in_aux;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_idx;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_res, in_aux, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid
  );

  modport slave (
    input  in_res, in_aux, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/mat_res_serializer.sv
// Serializes queued 2x2 matrix results MSB-first, one W-bit word per valid/ready transfer.
// First word visible the cycle after accept; in_ready tracks registered FIFO occupancy only.
module mat_res_serializer #(
  parameter int W        = 32,
  parameter int DEPTH    = 2,
  parameter bit EMIT_AUX = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mat_res_serializer_if.slave  bus,
  output logic [15:0]          res_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 5 * W;
  localparam logic [2:0] LAST_IDX = EMIT_AUX ? 3'd4 : 3'd3;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   res_count_q, res_count_d;

  logic          full;
  logic          push;
  logic          xfer;
  logic          last;
  logic          pop;
  logic          send;
  logic [EW-1:0] head;
  logic [W-1:0]  word;

  assign full         = (count_q == CW'(DEPTH));
  assign bus.in_ready = rst_n & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign send         = (state_q == S_SEND);
  assign head         = mem_q[rd_ptr_q];
  assign last         = (idx_q == LAST_IDX);
  assign xfer         = send & bus.out_ready;
  assign pop          = xfer & last;

  // Entry layout is {c00, c01, c10, c11, aux}, so idx walks from the top slice down.
  always_comb begin
    word = '0;
    case (idx_q)
      3'd0:    word = head[5*W-1 -: W];
      3'd1:    word = head[4*W-1 -: W];
      3'd2:    word = head[3*W-1 -: W];
      3'd3:    word = head[2*W-1 -: W];
      3'd4:    word = head[W-1:0];
      default: word = '0;
    endcase
  end

  assign bus.out_valid = send;
  assign bus.out_data  = send ? word  : '0;
  assign bus.out_idx   = send ? idx_q : 3'd0;
  assign bus.out_last  = send & last;
  assign res_count     = res_count_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    res_count_d = res_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_res, bus.in_aux};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (xfer) begin
      idx_d = last ? 3'd0 : idx_q + 3'd1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      res_count_d = res_count_q + 16'd1;
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Staying in SEND across a last-word pop keeps back-to-back results bubble-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (push) state_d = S_SEND;
      S_SEND: if (pop && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= 3'd0;
      res_count_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      res_count_q <= res_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end
endmodule

// File: tb/tb_mat_res_serializer.sv
// Directed bench for mat_res_serializer: one instance with aux word, one without,
// each checked against a queue of expected words built from the accepted inputs.
module tb_mat_res_serializer;
  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt_a_o, cnt_b_o;
  logic [15:0] cnt_a, cnt_b;
  exp_t        qa[$];
  exp_t        qb[$];
  int          errors = 0;
  int          checks = 0;

  mat_res_serializer_if #(.W(32)) ifa ();
  mat_res_serializer_if #(.W(32)) ifb ();

  mat_res_serializer #(.W(32), .DEPTH(2), .EMIT_AUX(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .res_count(cnt_a_o)
  );
  mat_res_serializer #(.W(32), .DEPTH(2), .EMIT_AUX(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .res_count(cnt_b_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [127:0] r, input logic [31:0] a, input int i, input bit aux_on);
    exp_t e;
    logic [31:0] el [5];
    el[0] = r[127:96];
    el[1] = r[95:64];
    el[2] = r[63:32];
    el[3] = r[31:0];
    el[4] = a;
    e.dat  = el[i];
    e.idx  = 3'(i);
    e.last = aux_on ? (i == 4) : (i == 3);
    return e;
  endfunction

  // Called just after a falling edge: check what the DUTs present, book the transfers
  // and accepts the next rising edge will perform, then advance one cycle.
  task automatic tick();
    exp_t e;
    bit acc_a, acc_b;
    chk("a_res_count", 64'(cnt_a_o), 64'(cnt_a));
    chk("b_res_count", 64'(cnt_b_o), 64'(cnt_b));
    if (qa.size() == 0) begin
      chk("a_idle_valid", 64'(ifa.out_valid), 64'd0);
      chk("a_idle_zero", 64'({ifa.out_data, ifa.out_idx, ifa.out_last}), 64'd0);
    end else begin
      e = qa[0];
      chk("a_valid", 64'(ifa.out_valid), 64'd1);
      chk("a_data", 64'(ifa.out_data), 64'(e.dat));
      chk("a_idx", 64'(ifa.out_idx), 64'(e.idx));
      chk("a_last", 64'(ifa.out_last), 64'(e.last));
      if (ifa.out_ready) begin
        if (e.last) cnt_a = cnt_a + 16'd1;
        void'(qa.pop_front());
      end
    end
    if (qb.size() == 0) begin
      chk("b_idle_valid", 64'(ifb.out_valid), 64'd0);
      chk("b_idle_zero", 64'({ifb.out_data, ifb.out_idx, ifb.out_last}), 64'd0);
    end else begin
      e = qb[0];
      chk("b_valid", 64'(ifb.out_valid), 64'd1);
      chk("b_data", 64'(ifb.out_data), 64'(e.dat));
      chk("b_idx", 64'(ifb.out_idx), 64'(e.idx));
      chk("b_last", 64'(ifb.out_last), 64'(e.last));
      if (ifb.out_ready) begin
        if (e.last) cnt_b = cnt_b + 16'd1;
        void'(qb.pop_front());
      end
    end
    acc_a = ifa.in_valid && ifa.in_ready;
    acc_b = ifb.in_valid && ifb.in_ready;
    if (acc_a) for (int i = 0; i < 5; i++) qa.push_back(mk(ifa.in_res, ifa.in_aux, i, 1'b1));
    if (acc_b) for (int i = 0; i < 4; i++) qb.push_back(mk(ifb.in_res, ifb.in_aux, i, 1'b0));
    @(posedge clk);
    @(negedge clk);
    if (acc_a) ifa.in_valid = 1'b0;
    if (acc_b) ifb.in_valid = 1'b0;
  endtask

  task automatic set_in(input logic [127:0] r, input logic [31:0] a);
    ifa.in_res = r; ifa.in_aux = a; ifa.in_valid = 1'b1;
    ifb.in_res = r; ifb.in_aux = a; ifb.in_valid = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    ifa.out_ready = v;
    ifb.out_ready = v;
  endtask

  initial begin
    cnt_a = 16'd0;
    cnt_b = 16'd0;
    ifa.in_res = '0; ifa.in_aux = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_res = '0; ifb.in_aux = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_out_zero", 64'({ifa.out_data, ifa.out_idx, ifa.out_last}), 64'd0);
    chk("rst_res_count", 64'(cnt_a_o), 64'd0);
    chk("rst_b_in_ready", 64'(ifb.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(ifa.in_ready), 64'd1);
    @(negedge clk);

    // Basic result: -1, 2, 3, 4 with aux 7
    set_ready(1'b1);
    set_in({32'hFFFF_FFFF, 32'd2, 32'd3, 32'd4}, 32'd7);
    repeat (8) tick();
    chk("basic_a_count", 64'(cnt_a_o), 64'd1);
    chk("basic_b_count", 64'(cnt_b_o), 64'd1);

    // Back-pressure on idx 2
    set_in({32'h1111_0000, 32'h2222_0000, 32'h8000_0003, 32'h4444_0000}, 32'hA5A5_A5A5);
    repeat (3) tick();
    chk("bp_idx_at_stall", 64'(ifa.out_idx), 64'd2);
    set_ready(1'b0);
    repeat (3) tick();
    chk("bp_hold_idx", 64'(ifa.out_idx), 64'd2);
    chk("bp_hold_data", 64'(ifa.out_data), 64'h8000_0003);
    set_ready(1'b1);
    repeat (4) tick();

    // Fill a depth-2 FIFO, third result held until a slot frees
    set_ready(1'b0);
    set_in({32'd10, 32'd11, 32'd12, 32'd13}, 32'd14);
    tick();
    set_in({32'd20, 32'd21, 32'd22, 32'd23}, 32'd24);
    tick();
    set_in({32'd30, 32'd31, 32'd32, 32'd33}, 32'd34);
    chk("fill_a_full", 64'(ifa.in_ready), 64'd0);
    chk("fill_b_full", 64'(ifb.in_ready), 64'd0);
    repeat (2) tick();
    chk("fill_a_held", 64'(ifa.in_valid), 64'd1);
    set_ready(1'b1);
    for (int t = 0; t < 20; t++) begin
      if (t == 4) chk("fill_a_ready_before_pop", 64'(ifa.in_ready), 64'd0);
      if (t == 5) chk("fill_a_ready_after_pop", 64'(ifa.in_ready), 64'd1);
      if (t == 3) chk("fill_b_ready_before_pop", 64'(ifb.in_ready), 64'd0);
      if (t == 4) chk("fill_b_ready_after_pop", 64'(ifb.in_ready), 64'd1);
      tick();
    end
    chk("fill_a_count", 64'(cnt_a_o), 64'd5);
    chk("fill_b_count", 64'(cnt_b_o), 64'd5);

    // Reset mid-result with a second entry queued
    set_in({32'd40, 32'd41, 32'd42, 32'd43}, 32'd44);
    tick();
    set_in({32'd50, 32'd51, 32'd52, 32'd53}, 32'd54);
    tick();
    chk("mid_idx_before_rst", 64'(ifa.out_idx), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ifa.out_valid), 64'd0);
    chk("mid_rst_zero", 64'({ifa.out_data, ifa.out_idx, ifa.out_last}), 64'd0);
    chk("mid_rst_count", 64'(cnt_a_o), 64'd0);
    chk("mid_rst_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("mid_rst_b_valid", 64'(ifb.out_valid), 64'd0);
    qa.delete();
    qb.delete();
    cnt_a = 16'd0;
    cnt_b = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_after_valid", 64'(ifa.out_valid), 64'd0);

    // Counter wrap from 0xFFFF
    force dut_a.res_count_q = 16'hFFFF;
    force dut_b.res_count_q = 16'hFFFF;
    #1;
    release dut_a.res_count_q;
    release dut_b.res_count_q;
    cnt_a = 16'hFFFF;
    cnt_b = 16'hFFFF;
    set_in({32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF}, 32'h0BAD_F00D);
    repeat (8) tick();
    chk("wrap_a_count", 64'(cnt_a_o), 64'd0);
    chk("wrap_b_count", 64'(cnt_b_o), 64'd0);
    chk("end_a_queue_empty", 64'(qa.size()), 64'd0);
    chk("end_b_queue_empty", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mat_res_serializer.md
# mat_res_serializer

Drains packed 2x2 matrix-multiply results (four signed 32-bit elements in one 128-bit word plus one 32-bit auxiliary result word) from the `Mat_mult` output side. Results are streamed out one 32-bit word per transfer over a valid/ready interface. A small result FIFO lets the multiplier hand off a new result while the previous one is still being serialized. A wrapping result counter supports bench and debug bookkeeping.

## Interface
Parameters:
- `W`, 32, element width in bits; the packed result is 4*W bits.
- `DEPTH`, 2, result FIFO entries; legal values are 2, 4, 8.
- `EMIT_AUX`, 1, when 1 the aux word is sent as the 5th word of each result; when 0, 4 words are sent.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_res`  in  4*W  packed result, signed elements.
- `in_aux`  in  W  auxiliary result word, stored with the entry.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  FIFO can accept a result.
- `out_data`  out  W  current serialized word.
- `out_idx`  out  3  word index within the result (0..4).
- `out_last`  out  1  current word is the final word of the result.
- `out_valid`  out  1  `out_data`, `out_idx` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the word.
- `res_count`  out  16  number of results fully drained; wraps.

## Operation
- Accept on a rising edge when `in_valid` and `in_ready` are both high. The entry stores `{in_res, in_aux}`.
- `in_ready` = `rst_n` AND (occupancy != `DEPTH`). It depends only on registered state, never combinationally on `out_ready`. When full, a simultaneous pop does not enable a push in the same cycle.
- Word order is MSB-first:
  - idx 0 = `in_res[4W-1:3W]` (c00)
  - idx 1 = `[3W-1:2W]` (c01)
  - idx 2 = `[2W-1:W]` (c10)
  - idx 3 = `[W-1:0]` (c11)
  - idx 4 = aux (only when `EMIT_AUX`=1)
- Words pass through bit-exact, with no sign extension or arithmetic.
- `out_last` is high on idx 4 when `EMIT_AUX`=1, and on idx 3 when `EMIT_AUX`=0.
- A word transfers on a rising edge when `out_valid` and `out_ready` are both high. The word index then increments. On a transfer of the last word:
  - the index clears to 0;
  - the head entry is popped;
  - `res_count` increments, wrapping from 0xFFFF to 0.
- Output state machine:
  - IDLE (FIFO empty, `out_valid`=0). Moves to SEND when the FIFO becomes non-empty.
  - SEND (`out_valid`=1). On a last-word transfer, stays in SEND if another entry is queued (no bubble); otherwise goes to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
- `out_data`, `out_idx` and `out_last` are forced to 0 whenever `out_valid`=0.
- Simultaneous push and pop with the FIFO not full: both take effect and occupancy is unchanged.
- The read and write pointers wrap modulo `DEPTH`.

## Timing
- Reset (async assert, rst_n=0): FIFO empty, word index 0, state IDLE.
  - Output values during reset: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `res_count`=0.
- Reset deassertion is taken synchronously: the first accept can occur on the first rising edge with `rst_n`=1.
- Latency: a result accepted at edge N into an empty FIFO shows `out_valid`=1 with idx 0 after edge N.
- Throughput with `out_ready` held high is 1 word per cycle. With `EMIT_AUX`=1 that is 5 cycles per result, back to back.
- `in_ready` rises the cycle after the pop that frees a slot in a full FIFO.
- Reset mid-result: the partial result and all queued entries are discarded immediately. Outputs go to their reset values asynchronously.
- Behaviour is undefined if `in_res` or `in_aux` change while `in_valid`=1 and `in_ready`=0. The producer must hold them stable.

## Test plan
- Reset, then push `in_res`={-1, 2, 3, 4} (32-bit each), `in_aux`=7, with `out_ready`=1 → words 0xFFFFFFFF, 2, 3, 4, 7 on consecutive cycles, idx 0..4, `out_last` only on 7, `res_count`=1.
- `EMIT_AUX`=0 with the same stimulus → 4 words, `out_last` on 4, aux never emitted.
- Back-pressure: hold `out_ready`=0 for 3 cycles on idx 2 → `out_data`=3 and idx 2 stable throughout; word 4 follows the cycle after `out_ready`=1.
- Fill: `out_ready`=0, push 3 results with `DEPTH`=2 → `in_ready`=0 after 2 accepts and the 3rd is held. Release `out_ready` → 15 words with no gaps, 3rd result accepted one cycle after the first pop, `res_count`=3.
- Asserting `rst_n`=0 during idx 1 with a second entry queued → `out_valid`=0 immediately. After release, `out_valid` stays 0 until a new push, and `res_count`=0.
- Preload `res_count` to 0xFFFF by draining 65535 results (or force it in the bench), then drain one more → `res_count`=0.
